// File: rtl/arbiter_control.sv
// Two-requester L2 port arbiter: data cache wins by default, but the instruction
// cache is guaranteed a grant after MAX_D_STREAK back-to-back data grants.
module arbiter_control #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ipmem_read,
    input  logic ipmem_write,
    input  logic dpmem_read,
    input  logic dpmem_write,
    input  logic pmem_resp,
    output logic instr_service,
    output logic data_service,
    output logic ipmem_resp,
    output logic dpmem_resp,
    output logic timeout_err
);

    localparam int SW_RAW = $clog2(MAX_D_STREAK + 1);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int WW_RAW = $clog2(TIMEOUT + 1);
    localparam int WW     = (WW_RAW < 8) ? 8 : WW_RAW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BUSY  = 2'd1,
        I_BUSY  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] d_streak, streak_d;
    logic [WW-1:0] wait_cnt, wait_d, wait_inc;
    logic          set_err;
    logic          ireq, dreq;

    assign ireq     = ipmem_read | ipmem_write;
    assign dreq     = dpmem_read | dpmem_write;
    assign wait_inc = wait_cnt + WW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_streak    <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_streak <= streak_d;
            wait_cnt <= wait_d;
            if (set_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = d_streak;
        wait_d   = wait_cnt;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq && (!ireq || (d_streak < SW'(MAX_D_STREAK)))) begin
                    state_d = D_BUSY;
                    wait_d  = '0;
                    if (!ireq) begin
                        streak_d = '0;
                    end else if (d_streak != SW'(MAX_D_STREAK)) begin
                        streak_d = d_streak + SW'(1);
                    end
                end else if (ireq) begin
                    state_d  = I_BUSY;
                    wait_d   = '0;
                    streak_d = '0;
                end
            end
            D_BUSY, I_BUSY: begin
                // A response arriving on the timeout cycle still counts as success.
                if (pmem_resp) begin
                    state_d = RECOVER;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WW'(TIMEOUT)) begin
                        state_d = RECOVER;
                        set_err = 1'b1;
                    end
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoded from the state register so reset drops the grant immediately.
    assign data_service  = (state_q == D_BUSY);
    assign instr_service = (state_q == I_BUSY);
    assign dpmem_resp    = pmem_resp & (state_q == D_BUSY);
    assign ipmem_resp    = pmem_resp & (state_q == I_BUSY);

endmodule

// File: tb/tb_arbiter_control.sv
// Directed bench for arbiter_control with MAX_D_STREAK=4 and TIMEOUT=8.
module tb_arbiter_control;

    logic clk = 1'b0;
    logic rst_n;
    logic ipmem_read, ipmem_write, dpmem_read, dpmem_write, pmem_resp;
    logic instr_service, data_service, ipmem_resp, dpmem_resp, timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arbiter_control #(
        .MAX_D_STREAK(4),
        .TIMEOUT     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ipmem_read   (ipmem_read),
        .ipmem_write  (ipmem_write),
        .dpmem_read   (dpmem_read),
        .dpmem_write  (dpmem_write),
        .pmem_resp    (pmem_resp),
        .instr_service(instr_service),
        .data_service (data_service),
        .ipmem_resp   (ipmem_resp),
        .dpmem_resp   (dpmem_resp),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic is, input logic ds,
                             input logic ir, input logic dr, input logic te);
        check({tag, ".instr_service"}, instr_service, is);
        check({tag, ".data_service"},  data_service,  ds);
        check({tag, ".ipmem_resp"},    ipmem_resp,    ir);
        check({tag, ".dpmem_resp"},    dpmem_resp,    dr);
        check({tag, ".timeout_err"},   timeout_err,   te);
    endtask

    initial begin
        rst_n = 1'b0;
        ipmem_read = 0; ipmem_write = 0; dpmem_read = 0; dpmem_write = 0; pmem_resp = 0;
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_all("idle_after_reset", 0, 0, 0, 0, 0);

        // Lone d-read, response in third busy cycle
        dpmem_read = 1;
        tick();
        check_all("dread_c1", 0, 1, 0, 0, 0);
        tick();
        check_all("dread_c2", 0, 1, 0, 0, 0);
        tick();
        pmem_resp = 1;
        #1;
        check_all("dread_c3_resp", 0, 1, 0, 1, 0);
        tick();
        pmem_resp = 0;
        #1;
        check_all("dread_recover", 0, 0, 0, 0, 0);
        dpmem_read = 0;
        tick();
        check_all("dread_idle", 0, 0, 0, 0, 0);

        // i-write only
        ipmem_write = 1;
        tick();
        check_all("iwrite_busy", 1, 0, 0, 0, 0);
        pmem_resp = 1;
        #1;
        check_all("iwrite_resp", 1, 0, 1, 0, 0);
        tick();
        pmem_resp = 0;
        ipmem_write = 0;
        #1;
        check_all("iwrite_recover", 0, 0, 0, 0, 0);
        tick();

        // Both requesters held, L2 answers immediately: D,D,D,D,I repeating
        ipmem_read = 1; dpmem_read = 1; pmem_resp = 1;
        for (int g = 0; g < 10; g++) begin
            tick();
            check($sformatf("streak_g%0d.instr", g), instr_service, (g % 5) == 4);
            check($sformatf("streak_g%0d.data", g),  data_service,  (g % 5) != 4);
            check($sformatf("streak_g%0d.dresp", g), dpmem_resp,    (g % 5) != 4);
            tick();
            check($sformatf("streak_g%0d.rec", g), instr_service | data_service, 1'b0);
            if (g == 9) begin
                ipmem_read = 0; dpmem_read = 0; pmem_resp = 0;
            end
            tick();
        end
        check_all("streak_done", 0, 0, 0, 0, 0);

        // Timeout: no response for 8 busy cycles
        dpmem_write = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("to_c%0d.data", c), data_service, 1'b1);
            check($sformatf("to_c%0d.err", c),  timeout_err,  1'b0);
        end
        tick();
        check_all("to_recover", 0, 0, 0, 0, 1);
        dpmem_write = 0;
        pmem_resp = 1;
        #1;
        check_all("to_late_resp", 0, 0, 0, 0, 1);
        tick();
        pmem_resp = 0;
        tick();
        check_all("to_sticky", 0, 0, 0, 0, 1);

        rst_n = 0;
        #1;
        check_all("to_cleared", 0, 0, 0, 0, 0);
        rst_n = 1;
        tick();

        // Response on the timeout cycle wins
        dpmem_read = 1;
        for (int c = 1; c <= 7; c++) begin
            tick();
        end
        check_all("race_c7", 0, 1, 0, 0, 0);
        tick();
        pmem_resp = 1;
        #1;
        check_all("race_c8_resp", 0, 1, 0, 1, 0);
        tick();
        pmem_resp = 0; dpmem_read = 0;
        #1;
        check_all("race_recover", 0, 0, 0, 0, 0);
        tick();

        // Reset mid I_BUSY
        ipmem_read = 1;
        tick();
        check_all("rst_ibusy", 1, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        check_all("rst_async", 0, 0, 0, 0, 0);
        ipmem_read = 0;
        pmem_resp = 1;
        #1;
        rst_n = 1;
        #1;
        check_all("rst_late_resp", 0, 0, 0, 0, 0);
        tick();
        check_all("rst_idle", 0, 0, 0, 0, 0);

        // Spurious response in IDLE
        #1;
        check_all("spur_idle", 0, 0, 0, 0, 0);
        tick();
        pmem_resp = 0;
        dpmem_read = 1;
        tick();
        check_all("spur_then_grant", 0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arbiter_control.md
ARBITER_CONTROL -- requirements
Module: arbiter_control

Interface
REQ-001 Parameter MAX_D_STREAK, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 255: cycles a grant may stay outstanding without pmem_resp.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ipmem_read, ipmem_write  input  1 each  i-cache request to L2.
REQ-007 dpmem_read, dpmem_write  input  1 each  d-cache request to L2.
REQ-008 pmem_resp  input  1  L2 completion strobe.
REQ-009 instr_service  output  1  steers the i-cache request onto the L2 port in the arbiter datapath.
REQ-010 data_service  output  1  steers the d-cache request onto the L2 port in the arbiter datapath.
REQ-011 ipmem_resp  output  1  completion to the i-cache.
REQ-012 dpmem_resp  output  1  completion to the d-cache.
REQ-013 timeout_err  output  1  sticky flag: a grant timed out.

Function
REQ-014 Define ireq = ipmem_read|ipmem_write and dreq = dpmem_read|dpmem_write; read+write together counts as one request and passes through unchanged.
REQ-015 The FSM SHALL have exactly the states IDLE, D_BUSY, I_BUSY and RECOVER.
REQ-016 Outputs are decoded from state only: data_service=1 only in D_BUSY; instr_service=1 only in I_BUSY; the two are never both 1.
REQ-017 IDLE: if dreq and (!ireq or d_streak<MAX_D_STREAK), go to D_BUSY; else if ireq, go to I_BUSY; else stay in IDLE.
REQ-018 Grant latency: a request sampled in IDLE at edge N has its service signal high from edge N until the grant ends.
REQ-019 D_BUSY/I_BUSY: the grant is held until pmem_resp=1, and the requester SHALL hold its request.
REQ-020 dpmem_resp = pmem_resp & (state==D_BUSY); ipmem_resp = pmem_resp & (state==I_BUSY); both are combinational and last one cycle.
REQ-021 On pmem_resp in a BUSY state, the next state is RECOVER.
REQ-022 RECOVER lasts exactly one cycle with both services 0, then returns to IDLE, so a stale request is never re-granted.
REQ-023 pmem_resp in IDLE or RECOVER is ignored: no resp is forwarded and state is unchanged.
REQ-024 d_streak (width clog2(MAX_D_STREAK+1)) behaviour on each grant:
- D grant with ireq=1: increments, saturating at MAX_D_STREAK.
- D grant with ireq=0: clears to 0.
- I grant: clears to 0.
REQ-025 wait_cnt (8 bits minimum, sized to hold TIMEOUT) clears on entry to a BUSY state and increments each BUSY cycle without pmem_resp.
REQ-026 When wait_cnt reaches TIMEOUT, the FSM goes to RECOVER, forwards no resp, and sets timeout_err.
REQ-027 timeout_err stays set until reset.
REQ-028 Simultaneous pmem_resp and timeout in the same cycle: the resp wins, is forwarded, and timeout_err is not set.

Reset
REQ-029 While rst_n=0, asynchronously:
- state=IDLE; d_streak=0; wait_cnt=0.
- instr_service, data_service, ipmem_resp, dpmem_resp and timeout_err all 0.
REQ-030 Reset asserted during a BUSY state drops the service immediately and no resp is forwarded.
REQ-031 After rst_n deasserts, the first grant decision is made at the next rising edge.

Verification
REQ-032 Lone d-read, L2 responds after 3 cycles -> data_service high 3 cycles, dpmem_resp pulses once, 1 RECOVER cycle, then IDLE.
REQ-033 ireq and dreq held continuously, MAX_D_STREAK=4, L2 responds in 1 cycle -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 ireq only, with an i-write -> instr_service high; ipmem_resp pulses on pmem_resp; dpmem_resp stays 0.
REQ-035 dreq granted, L2 never responds, TIMEOUT=8 -> data_service drops after 8 BUSY cycles, timeout_err=1 and remains 1 until rst_n.
REQ-036 rst_n pulsed low mid I_BUSY -> instr_service=0 asynchronously; a later pmem_resp is ignored; state=IDLE.
REQ-037 Spurious pmem_resp in IDLE -> no resp outputs and no state change.
